// File: rtl/mixer_pipe.sv
// Three-stage complex mixer: (sr + j*si) * (lo +/- j*qlo), rounded half up, shifted, limited to IO_W.
// Define MIXER_PIPE_SAT_EN to clamp and count saturated samples; otherwise results wrap.
module mixer_pipe #(
  parameter int IO_W  = 16,
  parameter int SHIFT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic signed [IO_W-1:0] lo_i,
  input  logic signed [IO_W-1:0] qlo_i,
  input  logic signed [IO_W-1:0] signalr_i,
  input  logic signed [IO_W-1:0] signali_i,
  input  logic                   conj_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic signed [IO_W-1:0] signalr_o,
  output logic signed [IO_W-1:0] signali_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  input  logic                   clr_i,
  output logic [15:0]            sat_cnt_o
);

  localparam int PW = 2 * IO_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  function automatic logic signed [SW-1:0] sext(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = s + RND;
    return t >>> SHIFT;
  endfunction

  logic en;
  logic vld_p0, vld_p1;
  logic conj_p0, conj_p1;
  logic signed [IO_W-1:0] sr_p0, si_p0, lo_p0, qlo_p0;
  logic signed [PW-1:0]   rl_p1, iq_p1, rq_p1, il_p1;
  logic signed [SW-1:0]   re_sum, im_sum, re_sh, im_sh;
  logic signed [IO_W-1:0] re_lim, im_lim;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid_i;
      vld_p1 <= vld_p0;
    end
  end

  // ---- stage 1: input capture / stage 2: four full-precision products ----
  always_ff @(posedge clk_i) begin
    if (en) begin
      sr_p0   <= signalr_i;
      si_p0   <= signali_i;
      lo_p0   <= lo_i;
      qlo_p0  <= qlo_i;
      conj_p0 <= conj_i;
      rl_p1   <= sr_p0 * lo_p0;
      iq_p1   <= si_p0 * qlo_p0;
      rq_p1   <= sr_p0 * qlo_p0;
      il_p1   <= si_p0 * lo_p0;
      conj_p1 <= conj_p0;
    end
  end

  always_comb begin
    re_sum = sext(rl_p1) - sext(iq_p1);
    im_sum = sext(rq_p1) + sext(il_p1);
    if (conj_p1) begin
      re_sum = sext(rl_p1) + sext(iq_p1);
      im_sum = sext(il_p1) - sext(rq_p1);
    end
    re_sh = round_shift(re_sum);
    im_sh = round_shift(im_sum);
  end

`ifdef MIXER_PIPE_SAT_EN
  localparam logic signed [SW-1:0] MAXV = {{(SW-IO_W+1){1'b0}}, {(IO_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-IO_W+1){1'b1}}, {(IO_W-1){1'b0}}};

  function automatic logic signed [IO_W-1:0] sat_lim(input logic signed [SW-1:0] v);
    if (v > MAXV) return MAXV[IO_W-1:0];
    if (v < MINV) return MINV[IO_W-1:0];
    return v[IO_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [SW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  logic any_sat;
  logic [15:0] sat_cnt;

  assign re_lim    = sat_lim(re_sh);
  assign im_lim    = sat_lim(im_sh);
  assign any_sat   = clipped(re_sh) || clipped(im_sh);
  assign sat_cnt_o = sat_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_cnt <= '0;
    end else if (clr_i) begin
      sat_cnt <= '0;
    end else if (en && vld_p1 && any_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  assign re_lim    = re_sh[IO_W-1:0];
  assign im_lim    = im_sh[IO_W-1:0];
  assign sat_cnt_o = '0;

  wire unused_ok = &{1'b0, clr_i, re_sh[SW-1:IO_W], im_sh[SW-1:IO_W]};
`endif

  // ---- stage 3: limited result to the output port ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      signalr_o   <= '0;
      signali_o   <= '0;
    end else if (en) begin
      out_valid_o <= vld_p1;
      if (vld_p1) begin
        signalr_o <= re_lim;
        signali_o <= im_lim;
      end
    end
  end

endmodule

// File: tb/tb_mixer_pipe.sv
// Directed bench for mixer_pipe: scoreboard queue filled on input acceptance, drained on output transfer.
module tb_mixer_pipe;

  localparam int IO_W  = 16;
  localparam int SHIFT = 16;
`ifdef MIXER_PIPE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif
  localparam logic signed [15:0] S3_RE = SAT_ON ? 16'sh7FFF : 16'sh8000;

  logic clk_i, rst_ni;
  logic signed [IO_W-1:0] lo_i, qlo_i, signalr_i, signali_i;
  logic conj_i, in_valid_i, in_ready_o;
  logic signed [IO_W-1:0] signalr_o, signali_o;
  logic out_valid_o, out_ready_i, clr_i;
  logic [15:0] sat_cnt_o;

  mixer_pipe #(.IO_W(IO_W), .SHIFT(SHIFT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lo_i(lo_i), .qlo_i(qlo_i), .signalr_i(signalr_i), .signali_i(signali_i),
    .conj_i(conj_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .signalr_o(signalr_o), .signali_o(signali_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .clr_i(clr_i), .sat_cnt_o(sat_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    bit                 sat;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int n_assert = 0;
  int n_fail   = 0;
  int exp_sat  = 0;
  bit skip_sat = 1'b0;
  bit held_v   = 1'b0;
  logic signed [15:0] held_re, held_im;
  logic signed [15:0] v_sr[5], v_si[5], v_lo[5], v_qlo[5];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  function automatic exp_t mk(input logic signed [15:0] re, input logic signed [15:0] im, input bit s);
    exp_t e;
    e.re = re; e.im = im; e.sat = s;
    return e;
  endfunction

  function automatic void lim(input longint v, output logic signed [15:0] r, output bit s);
    s = 1'b0;
    r = 16'(v);
    if (SAT_ON) begin
      if (v > 32767) begin r = 16'h7FFF; s = 1'b1; end
      else if (v < -32768) begin r = 16'h8000; s = 1'b1; end
    end
  endfunction

  function automatic exp_t model(input logic signed [15:0] sr, input logic signed [15:0] si,
                                 input logic signed [15:0] lo, input logic signed [15:0] qlo, input bit c);
    longint re_f, im_f;
    exp_t e;
    bit s_re, s_im;
    if (c) begin
      re_f = longint'(sr) * longint'(lo) + longint'(si) * longint'(qlo);
      im_f = longint'(si) * longint'(lo) - longint'(sr) * longint'(qlo);
    end else begin
      re_f = longint'(sr) * longint'(lo) - longint'(si) * longint'(qlo);
      im_f = longint'(sr) * longint'(qlo) + longint'(si) * longint'(lo);
    end
    re_f = (re_f + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    im_f = (im_f + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    lim(re_f, e.re, s_re);
    lim(im_f, e.im, s_im);
    e.sat = s_re | s_im;
    return e;
  endfunction

  // One clock cycle, entered and left at a falling edge; inputs are already driven.
  task automatic step(output bit acc);
    exp_t got;
    #2;
    acc = in_valid_i && in_ready_o;
    if (out_valid_o) begin
      if (held_v) begin
        check("hold_re", signalr_o, held_re);
        check("hold_im", signali_o, held_im);
      end
      if (out_ready_i) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          check("spurious_valid", out_valid_o, 1'b0);
        end else begin
          got = sb.pop_front();
          check("out_re", signalr_o, got.re);
          check("out_im", signali_o, got.im);
          if (skip_sat) skip_sat = 1'b0;
          else if (got.sat) exp_sat++;
          check("sat_cnt", sat_cnt_o, exp_sat);
        end
      end else begin
        held_v  = 1'b1;
        held_re = signalr_o;
        held_im = signali_o;
      end
    end else begin
      held_v = 1'b0;
    end
    if (acc) sb.push_back(nxt);
    @(negedge clk_i);
  endtask

  task automatic send(input logic signed [15:0] a_sr, input logic signed [15:0] a_si,
                      input logic signed [15:0] a_lo, input logic signed [15:0] a_qlo,
                      input bit c, input exp_t e);
    bit acc;
    int tries;
    signalr_i = a_sr; signali_i = a_si; lo_i = a_lo; qlo_i = a_qlo; conj_i = c;
    nxt = e;
    in_valid_i = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      step(acc);
      tries++;
    end
    in_valid_i = 1'b0;
    if (!acc) begin
      n_assert++;
      n_fail++;
      $error("FAIL accept_timeout: observed no acceptance in %0d cycles, expected acceptance", tries);
    end
  endtask

  task automatic drain();
    bit a;
    int t;
    out_ready_i = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      step(a);
      t++;
    end
    check("drain_left", sb.size(), 0);
    step(a);
    step(a);
  endtask

  task automatic send_model(input logic signed [15:0] a_sr, input logic signed [15:0] a_si,
                            input logic signed [15:0] a_lo, input logic signed [15:0] a_qlo, input bit c);
    send(a_sr, a_si, a_lo, a_qlo, c, model(a_sr, a_si, a_lo, a_qlo, c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a;
    int sent;
    rst_ni = 1'b0;
    lo_i = '0; qlo_i = '0; signalr_i = '0; signali_i = '0;
    conj_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; clr_i = 1'b0;
    nxt = mk(0, 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_signalr", signalr_o, 0);
    check("rst_signali", signali_o, 0);
    check("rst_sat_cnt", sat_cnt_o, 0);
    check("rst_in_ready", in_ready_o, 1'b1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Scenario 1 with latency probing.
    send(16384, 0, 16384, 0, 1'b0, mk(4096, 0, 0));
    check("s1_lat_c1", out_valid_o, 1'b0);
    step(a);
    check("s1_lat_c2", out_valid_o, 1'b0);
    step(a);
    check("s1_lat_c3", out_valid_o, 1'b1);
    step(a);
    check("s1_one_cycle", out_valid_o, 1'b0);

    // Scenario 2: both conj settings back to back.
    send(0, 16384, 0, 16384, 1'b0, mk(-4096, 0, 0));
    send(0, 16384, 0, 16384, 1'b1, mk(4096, 0, 0));
    drain();

    // Scenario 3: extreme operands.
    send(-32768, -32768, -32768, 32767, 1'b0, mk(S3_RE, 1, SAT_ON));
    drain();
    check("s3_sat_cnt", sat_cnt_o, SAT_ON ? 1 : 0);

    // Scenario 4: rounding of a half LSB.
    send(1, 0, -32768, 0, 1'b0, mk(0, 0, 0));
    drain();

    // Random operands, alternating conj, streamed back to back.
    for (int i = 0; i < 8; i++) begin
      send_model(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), i[0]);
    end
    drain();

    // Scenario 5: five samples with a six-cycle output stall.
    for (int i = 0; i < 5; i++) begin
      v_sr[i] = 16'($urandom); v_si[i] = 16'($urandom);
      v_lo[i] = 16'($urandom); v_qlo[i] = 16'($urandom);
    end
    sent = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      out_ready_i = !(c >= 4 && c < 10);
      if (sent < 5) begin
        signalr_i = v_sr[sent]; signali_i = v_si[sent]; lo_i = v_lo[sent]; qlo_i = v_qlo[sent];
        conj_i = sent[0];
        nxt = model(v_sr[sent], v_si[sent], v_lo[sent], v_qlo[sent], sent[0]);
        in_valid_i = 1'b1;
      end
      #1;
      if (c >= 4 && c < 10) check("s5_stall_ready", in_ready_o, 1'b0);
      step(a);
      if (a) sent++;
    end
    in_valid_i = 1'b0;
    check("s5_sent", sent, 5);
    drain();

    // Scenario 6a: reset with samples in flight.
    send_model(1000, -2000, 3000, 4000, 1'b0);
    send_model(-500, 700, 12000, -9000, 1'b1);
    send_model(20000, 20000, 20000, 20000, 1'b0);
    check("s6_pre_valid", out_valid_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check("s6_rst_valid", out_valid_o, 1'b0);
    check("s6_rst_signalr", signalr_o, 0);
    check("s6_rst_signali", signali_o, 0);
    check("s6_rst_in_ready", in_ready_o, 1'b1);
    sb.delete();
    exp_sat = 0;
    held_v = 1'b0;
    @(negedge clk_i);
    step(a);
    step(a);
    rst_ni = 1'b1;
    send(16384, 0, 16384, 0, 1'b0, mk(4096, 0, 0));
    drain();

    // Scenario 6b: clear colliding with a saturated sample.
    send(-32768, -32768, -32768, 32767, 1'b0, mk(S3_RE, 1, SAT_ON));
    drain();
    check("s6_sat_before", sat_cnt_o, SAT_ON ? 1 : 0);
    send(-32768, -32768, -32768, 32767, 1'b0, mk(S3_RE, 1, SAT_ON));
    step(a);
    clr_i = 1'b1;
    exp_sat = 0;
    skip_sat = 1'b1;
    step(a);
    clr_i = 1'b0;
    check("s6_clr_cnt", sat_cnt_o, 0);
    check("s6_clr_valid", out_valid_o, 1'b1);
    drain();
    send(-32768, -32768, -32768, 32767, 1'b1, model(-32768, -32768, -32768, 32767, 1'b1));
    send(-32768, -32768, -32768, 32767, 1'b0, mk(S3_RE, 1, SAT_ON));
    drain();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
